// File: rtl/core_types_pkg.sv
// Shared core types and sizing for the banked physical-register free list.
package core_types_pkg;

  localparam int unsigned PR_COUNT                      = 128;
  localparam int unsigned LOG_PR_COUNT                  = $clog2(PR_COUNT);
  localparam int unsigned AR_COUNT                      = 32;
  localparam int unsigned PRF_BANK_COUNT                = 4;
  localparam int unsigned LOG_PRF_BANK_COUNT            = $clog2(PRF_BANK_COUNT);
  localparam int unsigned FREE_LIST_BANK_COUNT          = PRF_BANK_COUNT;
  localparam int unsigned FREE_LIST_LENGTH_PER_BANK     = PR_COUNT / FREE_LIST_BANK_COUNT;
  localparam int unsigned LOG_FREE_LIST_LENGTH_PER_BANK = $clog2(FREE_LIST_LENGTH_PER_BANK);
  localparam int unsigned FREE_LIST_COUNT_WIDTH         = $clog2(FREE_LIST_LENGTH_PER_BANK + 1);
  localparam int unsigned FREE_LIST_RESET_COUNT         =
    FREE_LIST_LENGTH_PER_BANK - (AR_COUNT / FREE_LIST_BANK_COUNT);
  localparam int unsigned FREE_LIST_LOWER_THRESHOLD     = 8;
  localparam int unsigned FREE_LIST_UPPER_THRESHOLD     = 24;

  typedef logic [LOG_PR_COUNT-1:0]                  pr_t;
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0] fl_idx_t;
  typedef logic [FREE_LIST_COUNT_WIDTH-1:0]         fl_cnt_t;

  // PR held in slot k of a bank after reset; PRs below AR_COUNT start mapped,
  // so the free image begins at AR_COUNT and strides by the bank count.
  function automatic pr_t reset_pr(input int unsigned bank_id, input int unsigned k);
    if (k < FREE_LIST_RESET_COUNT) begin
      return pr_t'(AR_COUNT + bank_id + k * FREE_LIST_BANK_COUNT);
    end else begin
      return pr_t'(0);
    end
  endfunction

endpackage

// File: rtl/free_list_bank_chk.sv
// Protocol checks for one free-list bank; reports illegal use without altering state.
module free_list_bank_chk
  import core_types_pkg::*;
#(
  parameter int unsigned BANK_ID = 0
) (
  input logic                          CLK,
  input logic                          nRST,
  input logic                          enq_valid,
  input logic [LOG_PRF_BANK_COUNT-1:0] enq_bank_bits,
  input logic                          deq_req,
  input fl_cnt_t                       count
);

  // Sample each request against the occupancy it sees at the clock edge.
  always @(posedge CLK) begin
    if (nRST) begin
      assert (!(deq_req && (count == fl_cnt_t'(0))))
        else $warning("bank %0d: dequeue request on empty bank ignored", BANK_ID);
      assert (!(enq_valid && (count == fl_cnt_t'(FREE_LIST_LENGTH_PER_BANK))))
        else $warning("bank %0d: enqueue into full bank dropped", BANK_ID);
      assert (!(enq_valid && (enq_bank_bits != LOG_PRF_BANK_COUNT'(BANK_ID))))
        else $warning("bank %0d: enqueued PR belongs to another bank", BANK_ID);
    end
  end

endmodule

// File: rtl/free_list_bank_fifo.sv
// One bank of the free list: circular FIFO of PR tags with occupancy and watermarks.
module free_list_bank_fifo
  import core_types_pkg::*;
#(
  parameter int unsigned BANK_ID = 0
) (
  input  logic    CLK,
  input  logic    nRST,
  input  logic    enq_valid,
  input  pr_t     enq_pr,
  input  logic    deq_req,
  output logic    deq_valid,
  output pr_t     deq_pr,
  output fl_cnt_t count,
  output logic    bank_low,
  output logic    bank_high
);

  localparam fl_cnt_t CNT_ZERO  = fl_cnt_t'(0);
  localparam fl_cnt_t CNT_ONE   = fl_cnt_t'(1);
  localparam fl_cnt_t CNT_FULL  = fl_cnt_t'(FREE_LIST_LENGTH_PER_BANK);
  localparam fl_cnt_t CNT_LOW   = fl_cnt_t'(FREE_LIST_LOWER_THRESHOLD);
  localparam fl_cnt_t CNT_HIGH  = fl_cnt_t'(FREE_LIST_UPPER_THRESHOLD);
  localparam fl_idx_t IDX_ONE   = fl_idx_t'(1);

  pr_t     entries_q [FREE_LIST_LENGTH_PER_BANK];
  pr_t     entries_d [FREE_LIST_LENGTH_PER_BANK];
  fl_idx_t head_q, head_d;
  fl_idx_t tail_q, tail_d;
  fl_cnt_t count_q, count_d;
  logic    push_s;
  logic    pop_s;

  // Next-state: a pop needs a non-empty bank, a push needs a non-full bank.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pop_s     = deq_req & (count_q != CNT_ZERO);
    push_s    = enq_valid & (count_q != CNT_FULL);
    if (push_s) begin
      entries_d[tail_q] = enq_pr;
      tail_d            = tail_q + IDX_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + IDX_ONE;
    end else begin
      head_d = head_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset reloads this bank's initial free-PR image.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned k = 0; k < FREE_LIST_LENGTH_PER_BANK; k++) begin
        entries_q[k] <= reset_pr(BANK_ID, k);
      end
      head_q  <= fl_idx_t'(0);
      tail_q  <= fl_idx_t'(FREE_LIST_RESET_COUNT);
      count_q <= fl_cnt_t'(FREE_LIST_RESET_COUNT);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Outputs depend only on registered state; no enqueue-to-dequeue bypass.
  always_comb begin
    deq_valid = (count_q != CNT_ZERO);
    deq_pr    = entries_q[head_q];
    count     = count_q;
    bank_low  = (count_q < CNT_LOW);
    bank_high = (count_q > CNT_HIGH);
  end

endmodule

// File: rtl/prf_free_list_banked.sv
// Banked PR free list: one independent FIFO per PRF bank, wiring only.
module prf_free_list_banked
  import core_types_pkg::*;
(
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [FREE_LIST_BANK_COUNT-1:0]     enq_valid_by_bank,
  input  pr_t  [FREE_LIST_BANK_COUNT-1:0]     enq_PR_by_bank,
  input  logic [FREE_LIST_BANK_COUNT-1:0]     deq_req_by_bank,
  output logic [FREE_LIST_BANK_COUNT-1:0]     deq_valid_by_bank,
  output pr_t  [FREE_LIST_BANK_COUNT-1:0]     deq_PR_by_bank,
  output fl_cnt_t [FREE_LIST_BANK_COUNT-1:0]  count_by_bank,
  output logic [FREE_LIST_BANK_COUNT-1:0]     bank_low_by_bank,
  output logic [FREE_LIST_BANK_COUNT-1:0]     bank_high_by_bank
);

  for (genvar b = 0; b < FREE_LIST_BANK_COUNT; b++) begin : g_bank
    free_list_bank_fifo #(
      .BANK_ID (b)
    ) u_fifo (
      .CLK       (CLK),
      .nRST      (nRST),
      .enq_valid (enq_valid_by_bank[b]),
      .enq_pr    (enq_PR_by_bank[b]),
      .deq_req   (deq_req_by_bank[b]),
      .deq_valid (deq_valid_by_bank[b]),
      .deq_pr    (deq_PR_by_bank[b]),
      .count     (count_by_bank[b]),
      .bank_low  (bank_low_by_bank[b]),
      .bank_high (bank_high_by_bank[b])
    );

    free_list_bank_chk #(
      .BANK_ID (b)
    ) u_chk (
      .CLK           (CLK),
      .nRST          (nRST),
      .enq_valid     (enq_valid_by_bank[b]),
      .enq_bank_bits (enq_PR_by_bank[b][LOG_PRF_BANK_COUNT-1:0]),
      .deq_req       (deq_req_by_bank[b]),
      .count         (count_by_bank[b])
    );
  end

endmodule

// File: tb/tb_prf_free_list_banked.sv
// Scoreboard bench for the banked free list: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_prf_free_list_banked;

  logic            CLK;
  logic            nRST;
  logic [3:0]      enq_valid;
  logic [3:0][6:0] enq_pr;
  logic [3:0]      deq_req;
  logic [3:0]      deq_valid;
  logic [3:0][6:0] deq_pr;
  logic [3:0][5:0] count;
  logic [3:0]      bank_low;
  logic [3:0]      bank_high;

  typedef struct {
    int bank;
    int sel;
    int exp;
  } chk_t;

  chk_t chk_q[$];
  int   pop_q[4][$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp4[5]  = '{113, 117, 121, 125, 41};

  chk_t mon_c;
  int   mon_act;
  int   mon_exp;

  prf_free_list_banked dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .enq_valid_by_bank (enq_valid),
    .enq_PR_by_bank    (enq_pr),
    .deq_req_by_bank   (deq_req),
    .deq_valid_by_bank (deq_valid),
    .deq_PR_by_bank    (deq_pr),
    .count_by_bank     (count),
    .bank_low_by_bank  (bank_low),
    .bank_high_by_bank (bank_high)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic string sel_name(input int sel);
    case (sel)
      0:       return "deq_valid";
      1:       return "deq_PR";
      2:       return "count";
      3:       return "bank_low";
      4:       return "bank_high";
      default: return "unknown";
    endcase
  endfunction

  function automatic int actual(input int b, input int sel);
    case (sel)
      0:       return int'(deq_valid[b]);
      1:       return int'(deq_pr[b]);
      2:       return int'(count[b]);
      3:       return int'(bank_low[b]);
      4:       return int'(bank_high[b]);
      default: return -1;
    endcase
  endfunction

  task automatic expect_st(input int b, input int sel, input int v);
    chk_t c;
    c.bank = b;
    c.sel  = sel;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: status expectations every cycle, PR order on every accepted pop.
  always @(negedge CLK) begin
    while (chk_q.size() > 0) begin
      mon_c   = chk_q.pop_front();
      mon_act = actual(mon_c.bank, mon_c.sel);
      n_checks++;
      if (mon_act != mon_c.exp) begin
        n_fail++;
        $display("FAIL %s bank%0d at %0t: got %0d expected %0d",
                 sel_name(mon_c.sel), mon_c.bank, $time, mon_act, mon_c.exp);
      end
    end
    if (nRST) begin
      for (int b = 0; b < 4; b++) begin
        if (deq_req[b] && deq_valid[b]) begin
          n_checks++;
          if (pop_q[b].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pop bank%0d at %0t: got PR %0d expected no pop",
                     b, $time, deq_pr[b]);
          end else begin
            mon_exp = pop_q[b].pop_front();
            if (int'(deq_pr[b]) != mon_exp) begin
              n_fail++;
              $display("FAIL pop_order bank%0d at %0t: got PR %0d expected %0d",
                       b, $time, deq_pr[b], mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    nRST      = 1'b0;
    enq_valid = 4'b0000;
    enq_pr    = '0;
    deq_req   = 4'b0000;
    repeat (2) step();
    nRST = 1'b1;

    // Reset image on every bank.
    for (int b = 0; b < 4; b++) begin
      expect_st(b, 0, 1);
      expect_st(b, 1, 32 + b);
      expect_st(b, 2, 24);
      expect_st(b, 3, 0);
      expect_st(b, 4, 0);
    end

    // Drain bank 0 completely, then one ignored request on empty.
    for (int i = 0; i < 24; i++) begin
      deq_req[0] = 1'b1;
      pop_q[0].push_back(32 + 4 * i);
      expect_st(0, 2, 24 - i);
      expect_st(0, 3, ((24 - i) < 8) ? 1 : 0);
      step();
    end
    expect_st(0, 0, 0);
    expect_st(0, 2, 0);
    expect_st(0, 3, 1);
    step();
    deq_req[0] = 1'b0;

    // Enqueue into empty bank 0: visible only a cycle later.
    enq_valid[0] = 1'b1;
    enq_pr[0]    = 7'(40);
    expect_st(0, 0, 0);
    expect_st(0, 2, 0);
    step();
    enq_valid[0] = 1'b0;
    expect_st(0, 0, 1);
    expect_st(0, 1, 40);
    expect_st(0, 2, 1);
    deq_req[0] = 1'b1;
    pop_q[0].push_back(40);
    step();
    deq_req[0] = 1'b0;
    expect_st(0, 0, 0);
    expect_st(0, 2, 0);

    // Bank 1 down to 5, then simultaneous enqueue and pop.
    for (int i = 0; i < 19; i++) begin
      deq_req[1] = 1'b1;
      pop_q[1].push_back(33 + 4 * i);
      step();
    end
    expect_st(1, 2, 5);
    enq_valid[1] = 1'b1;
    enq_pr[1]    = 7'(41);
    pop_q[1].push_back(109);
    step();
    enq_valid[1] = 1'b0;
    expect_st(1, 2, 5);
    for (int i = 0; i < 5; i++) begin
      pop_q[1].push_back(exp4[i]);
      step();
    end
    deq_req[1] = 1'b0;
    expect_st(1, 0, 0);
    expect_st(1, 2, 0);

    // Bank 2 filled past the index wrap to full, overflow dropped.
    for (int i = 0; i < 8; i++) begin
      enq_valid[2] = 1'b1;
      enq_pr[2]    = 7'(2 + 4 * i);
      expect_st(2, 2, 24 + i);
      expect_st(2, 4, ((24 + i) > 24) ? 1 : 0);
      step();
    end
    enq_pr[2] = 7'(126);
    expect_st(2, 2, 32);
    expect_st(2, 4, 1);
    step();
    enq_valid[2] = 1'b0;
    expect_st(2, 2, 32);

    // Drain bank 2 across the head wrap; bank 3 pops in parallel.
    for (int i = 0; i < 32; i++) begin
      deq_req[2] = 1'b1;
      pop_q[2].push_back((i < 24) ? (34 + 4 * i) : (2 + 4 * (i - 24)));
      expect_st(2, 2, 32 - i);
      expect_st(2, 4, ((32 - i) > 24) ? 1 : 0);
      expect_st(2, 3, ((32 - i) < 8) ? 1 : 0);
      deq_req[3] = (i < 10) ? 1'b1 : 1'b0;
      if (i < 10) begin
        pop_q[3].push_back(35 + 4 * i);
      end
      step();
    end
    deq_req[2] = 1'b0;
    deq_req[3] = 1'b0;
    expect_st(2, 0, 0);
    expect_st(2, 2, 0);
    expect_st(3, 2, 14);
    expect_st(3, 1, 75);
    expect_st(0, 2, 0);
    expect_st(1, 2, 0);

    // Mixed traffic, then reset asserted mid-cycle.
    enq_valid[0] = 1'b1;
    enq_pr[0]    = 7'(44);
    enq_valid[1] = 1'b1;
    enq_pr[1]    = 7'(45);
    deq_req[3]   = 1'b1;
    pop_q[3].push_back(75);
    step();
    enq_valid = 4'b0000;
    expect_st(0, 2, 1);
    expect_st(1, 1, 45);
    pop_q[3].push_back(79);
    step();
    enq_valid[2] = 1'b1;
    enq_pr[2]    = 7'(6);
    nRST         = 1'b0;
    for (int b = 0; b < 4; b++) begin
      expect_st(b, 0, 1);
      expect_st(b, 1, 32 + b);
      expect_st(b, 2, 24);
      expect_st(b, 3, 0);
      expect_st(b, 4, 0);
    end
    step();
    nRST      = 1'b1;
    enq_valid = 4'b0000;
    deq_req   = 4'b0001;
    pop_q[0].push_back(32);
    expect_st(0, 2, 24);
    expect_st(3, 2, 24);
    step();
    deq_req = 4'b0000;
    expect_st(0, 2, 23);
    expect_st(0, 1, 36);
    step();
    @(negedge CLK);
    #1;

    // Every queued pop must have been observed.
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (pop_q[b].size() != 0) begin
        n_fail++;
        $display("FAIL pending_pops bank%0d: got %0d outstanding expected 0", b, pop_q[b].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
